// File: rtl/imem_load_ctrl.sv
// Run-time instruction memory loader: stalls the core, drains the pipeline, streams a program
// image into imem from word 0, then pulses a PC reset and releases the stall.
module imem_load_ctrl #(
  parameter int unsigned N            = 32,
  parameter int unsigned ADDR_W       = 7,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic [N-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N-1:0]      mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_rst_pc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   loaded_words
);

  localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [ADDR_W:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {StIdle, StFlush, StLoad, StRestart, StRelease} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   target_q;
  logic [ADDR_W:0]   count_q;
  logic [FlushW-1:0] flush_q;
  logic              hs;
  logic              last_word;
  logic              start_ok;
  logic              flush_end;

  // Abort takes priority over a same-cycle handshake, so it gates ready directly.
  assign in_ready     = (state_q == StLoad) && (count_q < target_q) && !abort;
  assign hs           = in_valid && in_ready;
  assign last_word    = (count_q + (ADDR_W + 1)'(1)) == target_q;
  assign start_ok     = (word_count != '0) && (word_count <= MaxWords);
  assign flush_end    = int'(flush_q) == int'(FLUSH_CYCLES) - 1;
  assign loaded_words = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      target_q   <= '0;
      count_q    <= '0;
      flush_q    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      cpu_rst_pc <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      cpu_rst_pc <= 1'b0;
      done       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (start_ok) begin
              target_q <= word_count;
              count_q  <= '0;
              flush_q  <= '0;
              err      <= 1'b0;
              cpu_hold <= 1'b1;
              busy     <= 1'b1;
              state_q  <= (FLUSH_CYCLES == 0) ? StLoad : StFlush;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StFlush: begin
          if (abort) begin
            err        <= 1'b1;
            cpu_rst_pc <= 1'b1;
            state_q    <= StRestart;
          end else if (flush_end) begin
            state_q <= StLoad;
          end else begin
            flush_q <= flush_q + FlushW'(1);
          end
        end
        StLoad: begin
          if (abort) begin
            err        <= 1'b1;
            cpu_rst_pc <= 1'b1;
            state_q    <= StRestart;
          end else if (hs) begin
            mem_we    <= 1'b1;
            mem_addr  <= count_q[ADDR_W-1:0];
            mem_wdata <= in_data;
            count_q   <= count_q + (ADDR_W + 1)'(1);
            if (last_word) begin
              cpu_rst_pc <= 1'b1;
              state_q    <= StRestart;
            end
          end
        end
        StRestart: begin
          // err is only set here by an abort of this load, so it suppresses done.
          cpu_hold <= 1'b0;
          done     <= !err;
          state_q  <= StRelease;
        end
        StRelease: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized scoreboard bench for imem_load_ctrl: expected imem writes are queued by the
// stimulus side and popped by an independent write monitor.
module tb_imem_load_ctrl;

  localparam int N  = 32;
  localparam int AW = 7;
  localparam int FC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          abort = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          cpu_hold;
  logic          cpu_rst_pc;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   loaded_words;

  imem_load_ctrl #(.N(N), .ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .word_count  (word_count),
    .abort       (abort),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_hold    (cpu_hold),
    .cpu_rst_pc  (cpu_rst_pc),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  done_cnt = 0;
  int  rstpc_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Write monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: addr %0d data %0h, none expected", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e.addr));
          chk("wr_data", 64'(mem_wdata), 64'(e.data));
        end
      end
      if (cpu_rst_pc) begin
        rstpc_cnt++;
        chk("hold_during_pc_reset", 64'(cpu_hold), 64'd1);
      end
      if (done) begin
        done_cnt++;
        chk("hold_low_at_done", 64'(cpu_hold), 64'd0);
      end
    end
  end

  // Model: ready only once FC flush cycles have elapsed, while words remain and no abort.
  task automatic run_load(input int wc, input int abort_at, input int valid_pct);
    int sent = 0;
    int k = 0;
    int t = 0;
    int d0 = done_cnt;
    int r0 = rstpc_cnt;
    bit aborted = 1'b0;
    bit exp_rdy;
    @(negedge clk);
    start = 1'b1;
    word_count = (AW + 1)'(wc);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (sent < wc && !aborted && k < 3000) begin
      in_valid = ($urandom_range(99) < valid_pct);
      in_data  = $urandom;
      abort    = in_valid && (sent == abort_at) && (k >= 1 + FC);
      #1;
      exp_rdy = (k >= 1 + FC) && !abort;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("hold_in_load", 64'(cpu_hold), 64'd1);
      if (abort) aborted = 1'b1;
      else if (exp_rdy && in_valid) begin
        exp_q.push_back({AW'(sent), in_data});
        sent++;
      end
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    abort = 1'b0;
    chk("load_progress", 64'(sent == wc || aborted), 64'd1);
    while (busy && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("busy_clears", 64'(busy), 64'd0);
    chk("hold_released", 64'(cpu_hold), 64'd0);
    chk("done_pulses", 64'(done_cnt - d0), aborted ? 64'd0 : 64'd1);
    chk("pc_reset_pulses", 64'(rstpc_cnt - r0), 64'd1);
    chk("err_flag", 64'(err), 64'(aborted));
    chk("loaded_words", 64'(loaded_words), 64'(sent));
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic bad_start(input int wc);
    int r0 = rstpc_cnt;
    @(negedge clk);
    start = 1'b1;
    word_count = (AW + 1)'(wc);
    @(negedge clk);
    start = 1'b0;
    chk("bad_err", 64'(err), 64'd1);
    chk("bad_busy", 64'(busy), 64'd0);
    chk("bad_hold", 64'(cpu_hold), 64'd0);
    @(negedge clk);
    chk("bad_hold_later", 64'(cpu_hold), 64'd0);
    chk("bad_no_pc_reset", 64'(rstpc_cnt - r0), 64'd0);
  endtask

  initial begin
    logic [N-1:0] words[3];
    int idx;
    int d0;
    int sent;
    int g;
    words[0] = 32'h8020000A;
    words[1] = 32'h0;
    words[2] = 32'h04400800;

    #1;
    chk("rst_hold", 64'(cpu_hold), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_loaded", 64'(loaded_words), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic cycle-accurate load of three words.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    word_count = 3;
    in_valid = 1'b1;
    in_data = words[0];
    idx = 0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k >= 6 && k <= 8) idx++;
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? words[idx] : '0;
      #1;
      chk($sformatf("basic_hold_c%0d", k), 64'(cpu_hold), 64'(k >= 1 && k <= 8));
      chk($sformatf("basic_ready_c%0d", k), 64'(in_ready), 64'(k >= 5 && k <= 7));
      chk($sformatf("basic_we_c%0d", k), 64'(mem_we), 64'(k >= 6 && k <= 8));
      chk($sformatf("basic_pcrst_c%0d", k), 64'(cpu_rst_pc), 64'(k == 8));
      chk($sformatf("basic_done_c%0d", k), 64'(done), 64'(k == 9));
      chk($sformatf("basic_busy_c%0d", k), 64'(busy), 64'(k <= 9));
      if (k >= 5 && k <= 7) exp_q.push_back({AW'(idx), words[idx]});
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("basic_loaded", 64'(loaded_words), 64'd3);
    chk("basic_done_once", 64'(done_cnt - d0), 64'd1);
    chk("basic_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure and random loads.
    run_load(2, -1, 40);
    for (int i = 0; i < 4; i++) run_load(int'($urandom_range(1, 20)), -1, int'($urandom_range(30, 100)));

    // Illegal counts.
    bad_start(0);
    bad_start(129);

    // Full depth.
    run_load(128, -1, 100);

    // Abort with the fifth handshake, then a clean load clears err.
    run_load(10, 4, 100);
    run_load(3, -1, 70);

    // Asynchronous reset in the middle of a load.
    @(negedge clk);
    start = 1'b1;
    word_count = 5;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    sent = 0;
    g = 0;
    while (sent < 2 && g < 50) begin
      in_data = $urandom;
      #1;
      if (in_ready) begin
        exp_q.push_back({AW'(sent), in_data});
        sent++;
      end
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("midload_hold_before", 64'(cpu_hold), 64'd1);
    chk("midload_loaded_before", 64'(loaded_words), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_hold", 64'(cpu_hold), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_pcrst", 64'(cpu_rst_pc), 64'd0);
    chk("arst_we", 64'(mem_we), 64'd0);
    chk("arst_loaded", 64'(loaded_words), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd0);
    chk("arst_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_load(128, -1, 60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Sequencer that reprograms the pipeline's instruction memory at run time from a valid/ready word stream.
- Freezes the pipeline and drains in-flight instructions.
- Writes a program image word-by-word starting at word address 0.
- Restarts the core by pulsing a PC-reset and then releasing the hold.
- Sits between the host/debug stream and the instruction memory's write port, and drives the core's global stall.

Parameters:
N, 32, instruction word width in bits
ADDR_W, 7, instruction word-address width (word address = PC[ADDR_W+1:2])
FLUSH_CYCLES, 4, hold cycles before the first write so in-flight pipeline stages retire

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request a load; sampled only in IDLE
word_count  in  ADDR_W+1  number of words to load; legal range 1..2^ADDR_W; latched on accepted start
abort  in  1  cancel an active load (FLUSH or LOAD)
in_data  in  N  program word
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts in_data this cycle
mem_we  out  1  instruction memory write strobe
mem_addr  out  ADDR_W  instruction memory word address
mem_wdata  out  N  instruction memory write data
cpu_hold  out  1  stall the whole pipeline (PC and pipeline registers frozen)
cpu_rst_pc  out  1  one-cycle pulse forcing PC to 0
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky error flag; cleared on the next accepted start
loaded_words  out  ADDR_W+1  number of words written in the current or last load

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; counters 0.
- All outputs are registered except in_ready, which is decoded from the registered state and counter.
- FSM states: IDLE, FLUSH, LOAD, RESTART, RELEASE.
- IDLE, start=1 with word_count in 1..2^ADDR_W:
  - latch word_count; clear err and loaded_words.
  - go to FLUSH; cpu_hold=1 from the next cycle.
- IDLE, start=1 with word_count=0 or >2^ADDR_W: err=1 next cycle; stay IDLE; cpu_hold stays 0.
- start while busy is ignored.
- FLUSH:
  - count FLUSH_CYCLES cycles with cpu_hold=1 and in_ready=0, then go to LOAD.
  - FLUSH_CYCLES=0 goes straight to LOAD the cycle after start.
- LOAD:
  - in_ready=1 while the accepted count is below the latched word_count.
  - Handshake: in_valid & in_ready at edge t gives mem_we=1, mem_addr=count, mem_wdata=in_data in cycle t+1; count and loaded_words increment.
  - mem_we=0 in any cycle without a handshake.
  - in_valid may stall arbitrarily; there is no timeout.
  - Addresses run 0..word_count-1 with no wrap; a 2^ADDR_W-word load ends at address 2^ADDR_W-1.
  - When the last word is accepted, in_ready=0 the same cycle it reaches count; the next state is RESTART, and the last write strobe appears during the first RESTART cycle.
- RESTART: cpu_rst_pc=1 for exactly one cycle; cpu_hold stays 1; go to RELEASE.
- RELEASE: cpu_hold=0 and done=1 for one cycle; return to IDLE.
  - First fetch from address 0 occurs no earlier than the cycle after cpu_hold falls.
- abort=1 in FLUSH or LOAD:
  - A handshake in the same cycle is not accepted; abort wins and in_ready is forced 0.
  - A write already registered from the previous cycle still completes.
  - err=1; go to RESTART then RELEASE (PC still reset, hold released); done stays 0 on abort.
- abort is ignored in IDLE, RESTART and RELEASE.
- Reset asserted mid-load: immediate return to IDLE, hold drops, no pc pulse; memory contents are undefined beyond loaded_words.
- Simultaneous start and abort in IDLE: start is processed and abort is ignored.

Test Plan:
- Basic load: reset, start with word_count=3, FLUSH_CYCLES=4, stream 0x8020000A, 0x0, 0x04400800 back-to-back → cpu_hold=1 from cycle 1; writes at addr 0,1,2 in cycles 6,7,8; cpu_rst_pc pulse in cycle 8; done and hold=0 in cycle 9; loaded_words=3.
- Backpressure: word_count=2, in_valid toggled 1,0,0,1 → exactly two mem_we pulses at addr 0 and 1; data matches the accepted words; no write during in_valid=0 gaps.
- Illegal count: start with word_count=0, then 129 (ADDR_W=7) → err=1 each time, busy=0, cpu_hold never asserted, no mem_we.
- Full depth: word_count=128 → addresses 0..127 written once each; no write to addr 0 after 127; done pulses once.
- Abort: word_count=10, abort asserted together with the 5th handshake → only 4 writes (addr 0..3); err=1; cpu_rst_pc pulses; hold released; done=0; a subsequent start clears err.
- Reset mid-LOAD after 2 writes → all outputs 0 immediately (asynchronous); a new start after reset release performs a clean full load.
